// File: rtl/input_debouncer.sv
// input_debouncer
// Per-channel two-flop synchronizer followed by a saturating-count bounce
// filter. Each channel drives a registered clean level plus one-cycle rise
// and fall pulses. Channels are fully independent; they share clk and reset.
module input_debouncer #(
  parameter  int WIDTH        = 4,
  parameter  int STABLE_COUNT = 1000000,
  localparam int CNT_W        = $clog2(STABLE_COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  // Last count value before a flip. Reaching it with the input still
  // disagreeing means STABLE_COUNT consecutive disagreeing samples were seen.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT - 1);

  // Synchronizer stages: sync1 may go metastable, sync2 is the clean copy.
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Filter state and registered outputs.
  logic [WIDTH-1:0] db_q,   db_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Filter next-state: count disagreeing samples, flip the level on the last one.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch,
    // otherwise a path that skips an assignment would infer a latch.
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          // Sampled value has held long enough: adopt it and announce the edge.
          db_d[i]   = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      // Agreement (or a completed flip) leaves cnt_d at zero, so any return
      // of the input to the current level discards a pending transition.
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, which is what makes sync2 lag sync1.
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      // NOTE: the counter array is small per-channel state, not a RAM, so it
      // is cleared with the rest; a stale count would shorten the first filter
      // window after reset.
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign db_out     = db_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule
